// File: rtl/spad_read_streamer.sv
// spad_read_streamer: issues a burst of scratchpad reads from base_addr and
// streams the returned words through a small FIFO onto a valid/ready output.
// Optional feature: define SPAD_STREAM_STRIDE_EN to add a per-command stride
// port; without it the address increment is fixed at 1.
//
// Handshakes: the output transfers a word on any rising edge where
// out_valid && out_ready; out_data/out_last are held stable while
// out_valid && !out_ready. The scratchpad side has no backpressure: data is
// returned the cycle after spad_read_req, so reads are only issued when the
// FIFO is guaranteed to have room for them.
module spad_read_streamer #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [ADDR_BITWIDTH:0]   num_words,
`ifdef SPAD_STREAM_STRIDE_EN
  input  logic [ADDR_BITWIDTH-1:0] stride,
`endif
  output logic                     spad_read_req,
  output logic [ADDR_BITWIDTH-1:0] spad_r_addr,
  input  logic [DATA_BITWIDTH-1:0] spad_r_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITWIDTH:0] ONE_N = (ADDR_BITWIDTH+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [ADDR_BITWIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_BITWIDTH:0]   num_q, num_d;
  logic                     done_q, done_d;
  logic                     inflight_q, inflight_last_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [PW:0]              count_q;
  logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                     last_mem_q [FIFO_DEPTH];

  logic                     issue, is_last_rd, push, pop, pop_last;
  logic [PW:0]              occ;
  logic [ADDR_BITWIDTH-1:0] stride_w;

`ifdef SPAD_STREAM_STRIDE_EN
  logic [ADDR_BITWIDTH-1:0] stride_q, stride_d;
  assign stride_w = stride_q;

  // Stride is captured with the command so later port changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stride_q <= '0;
    else       stride_q <= stride_d;
  end
`else
  assign stride_w = (ADDR_BITWIDTH)'(1);
`endif

  // Reads in flight are counted against FIFO space so returning data always fits.
  assign occ        = count_q + {{PW{1'b0}}, inflight_q};
  assign issue      = (state_q == ST_STREAM) && (occ < DEPTH_L);
  assign is_last_rd = (rd_cnt_q == num_q - ONE_N);
  assign push       = inflight_q;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  assign pop_last   = pop && last_mem_q[rd_ptr_q];

  assign spad_read_req = issue;
  assign spad_r_addr   = addr_q;
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last      = out_valid && last_mem_q[rd_ptr_q];
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign dbg_state_o   = state_q;

  // Next-state logic: command capture, read issue sequencing, completion.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_cnt_d = rd_cnt_q;
    num_d    = num_q;
    done_d   = 1'b0;
`ifdef SPAD_STREAM_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_STREAM;
            addr_d   = base_addr;
            rd_cnt_d = '0;
            num_d    = num_words;
`ifdef SPAD_STREAM_STRIDE_EN
            stride_d = stride;
`endif
          end
        end
      end
      ST_STREAM: begin
        if (issue) begin
          addr_d   = addr_q + stride_w;
          rd_cnt_d = rd_cnt_q + ONE_N;
          if (is_last_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and FIFO bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rd_cnt_q        <= '0;
      num_q           <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rd_cnt_q        <= rd_cnt_d;
      num_q           <= num_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && is_last_rd;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= spad_r_data;
      last_mem_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule

// File: tb/tb_spad_read_streamer.sv
// Directed bench for spad_read_streamer. Define SPAD_STREAM_STRIDE_EN to
// also cover the stride option.
module tb_spad_read_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic [9:0]  stride;
  logic        spad_read_req;
  logic [9:0]  spad_r_addr;
  logic [7:0]  spad_r_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc;

  int   rd_addr[$];
  int   rd_cyc[$];
  int   od[$];
  int   ol[$];
  int   oc[$];
  int   dn[$];
  logic       busy_tr  [64];
  logic       valid_tr [64];
  logic [7:0] dat_tr   [64];

  spad_read_streamer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
`ifdef SPAD_STREAM_STRIDE_EN
    .stride        (stride),
`endif
    .spad_read_req (spad_read_req),
    .spad_r_addr   (spad_r_addr),
    .spad_r_data   (spad_r_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .dbg_state_o   (dbg_state)
  );

  // clock / scratchpad model: word at address a is a[7:0] ^ 8'hA5
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spad_read_req) spad_r_data <= spad_r_addr[7:0] ^ 8'hA5;
  end

  task automatic clear_logs();
    rd_addr.delete(); rd_cyc.delete();
    od.delete(); ol.delete(); oc.delete(); dn.delete();
    for (int i = 0; i < 64; i++) begin
      busy_tr[i] = 1'b0; valid_tr[i] = 1'b0; dat_tr[i] = 8'h00;
    end
  endtask

  task automatic sample_now();
    if (cyc < 64) begin
      busy_tr[cyc]  = busy;
      valid_tr[cyc] = out_valid;
      dat_tr[cyc]   = out_data;
    end
    if (spad_read_req) begin
      rd_addr.push_back(int'(spad_r_addr));
      rd_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      od.push_back(int'(out_data));
      ol.push_back(int'(out_last));
      oc.push_back(cyc);
    end
    if (done) dn.push_back(cyc);
  endtask

  // driver: start pulse in cycle 0
  task automatic issue_cmd(input logic [9:0] b, input logic [10:0] n, input logic [9:0] s);
    @(negedge clk);
    clear_logs();
    cyc       = 0;
    base_addr = b;
    num_words = n;
    stride    = s;
    start     = 1'b1;
    out_ready = 1'b1;
    #1 sample_now();
  endtask

  // driver: cycles 1..ncyc, out_ready low for cycles <= hold, optional stray start
  task automatic run(input int ncyc, input int hold, input int start_at);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      cyc       = i;
      out_ready = (i > hold);
      start     = (i == start_at);
      if (i == start_at) begin
        base_addr = 10'h0AA;
        num_words = 11'd5;
      end
      #1 sample_now();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; stride = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({spad_read_req, out_valid, out_last, busy, done} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got req/val/last/busy/done=%b exp 00000",
               {spad_read_req, out_valid, out_last, busy, done});
    end
    n_checks++;
    if (spad_r_addr !== 10'h000 || out_data !== 8'h00 || dbg_state !== 2'd0) begin
      n_fails++;
      $display("FAIL reset_data: got addr=%h data=%h state=%0d exp 0/0/0", spad_r_addr, out_data, dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    issue_cmd(10'h010, 11'd8, 10'd1);
    run(14, 0, -1);
    n_checks++;
    if (rd_addr.size() !== 8) begin
      n_fails++; $display("FAIL basic_rd_count: got %0d exp 8", rd_addr.size());
    end
    for (int k = 0; k < 8 && k < rd_addr.size(); k++) begin
      n_checks++;
      if (rd_addr[k] !== 'h10 + k || rd_cyc[k] !== k + 1) begin
        n_fails++;
        $display("FAIL basic_rd[%0d]: got addr=%h cyc=%0d exp addr=%h cyc=%0d", k, rd_addr[k], rd_cyc[k], 'h10 + k, k + 1);
      end
    end
    n_checks++;
    if (od.size() !== 8) begin
      n_fails++; $display("FAIL basic_out_count: got %0d exp 8", od.size());
    end
    for (int k = 0; k < 8 && k < od.size(); k++) begin
      n_checks++;
      if (od[k] !== (('h10 + k) ^ 'hA5) || oc[k] !== k + 3 || ol[k] !== int'(k == 7)) begin
        n_fails++;
        $display("FAIL basic_out[%0d]: got data=%h cyc=%0d last=%0d exp data=%h cyc=%0d last=%0d",
                 k, od[k], oc[k], ol[k], ('h10 + k) ^ 'hA5, k + 3, int'(k == 7));
      end
    end
    n_checks++;
    if (valid_tr[2] !== 1'b0 || valid_tr[3] !== 1'b1) begin
      n_fails++; $display("FAIL basic_first_valid: got v2=%b v3=%b exp 0/1", valid_tr[2], valid_tr[3]);
    end
    n_checks++;
    if (dn.size() !== 1 || (dn.size() == 1 && dn[0] !== 11)) begin
      n_fails++; $display("FAIL basic_done: got count=%0d exp one pulse in cycle 11", dn.size());
    end
    n_checks++;
    if (busy_tr[0] !== 1'b0 || busy_tr[1] !== 1'b1 || busy_tr[10] !== 1'b1 || busy_tr[11] !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_busy: got b0/b1/b10/b11=%b%b%b%b exp 0110", busy_tr[0], busy_tr[1], busy_tr[10], busy_tr[11]);
    end
  endtask

  task automatic test_wrap();
    int exp_a [4];
    int exp_d [4];
    exp_a = '{'h3FE, 'h3FF, 'h000, 'h001};
    exp_d = '{'h5B, 'h5A, 'hA5, 'hA4};
    issue_cmd(10'h3FE, 11'd4, 10'd1);
    run(10, 0, -1);
    n_checks++;
    if (rd_addr.size() !== 4 || od.size() !== 4) begin
      n_fails++; $display("FAIL wrap_count: got rd=%0d out=%0d exp 4/4", rd_addr.size(), od.size());
    end
    for (int k = 0; k < 4 && k < rd_addr.size() && k < od.size(); k++) begin
      n_checks++;
      if (rd_addr[k] !== exp_a[k] || od[k] !== exp_d[k]) begin
        n_fails++;
        $display("FAIL wrap[%0d]: got addr=%h data=%h exp addr=%h data=%h", k, rd_addr[k], od[k], exp_a[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int early;
    issue_cmd(10'h020, 11'd16, 10'd1);
    run(45, 20, -1);
    early = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] <= 20) early++;
    n_checks++;
    if (early !== 4) begin
      n_fails++; $display("FAIL bp_stall_reads: got %0d exp 4", early);
    end
    n_checks++;
    if (valid_tr[20] !== 1'b1 || dat_tr[5] !== 8'h85 || dat_tr[20] !== 8'h85) begin
      n_fails++; $display("FAIL bp_hold: got v20=%b d5=%h d20=%h exp 1/85/85", valid_tr[20], dat_tr[5], dat_tr[20]);
    end
    n_checks++;
    if (rd_addr.size() !== 16 || od.size() !== 16 || (oc.size() > 0 && oc[0] !== 21)) begin
      n_fails++; $display("FAIL bp_count: got rd=%0d out=%0d exp 16/16 first at 21", rd_addr.size(), od.size());
    end
    for (int k = 0; k < 16 && k < od.size(); k++) begin
      n_checks++;
      if (od[k] !== (('h20 + k) ^ 'hA5) || ol[k] !== int'(k == 15)) begin
        n_fails++;
        $display("FAIL bp_out[%0d]: got data=%h last=%0d exp data=%h last=%0d", k, od[k], ol[k], ('h20 + k) ^ 'hA5, int'(k == 15));
      end
    end
    n_checks++;
    if (dn.size() !== 1 || (dn.size() == 1 && dn[0] !== 37)) begin
      n_fails++; $display("FAIL bp_done: got count=%0d exp one pulse in cycle 37", dn.size());
    end
  endtask

  task automatic test_zero();
    logic any_busy;
    issue_cmd(10'h123, 11'd0, 10'd1);
    run(5, 0, -1);
    any_busy = 1'b0;
    for (int i = 0; i <= 5; i++) any_busy |= busy_tr[i];
    n_checks++;
    if (rd_addr.size() !== 0 || any_busy !== 1'b0) begin
      n_fails++; $display("FAIL zero_idle: got reads=%0d busy=%b exp 0/0", rd_addr.size(), any_busy);
    end
    n_checks++;
    if (dn.size() !== 1 || (dn.size() == 1 && dn[0] !== 1)) begin
      n_fails++; $display("FAIL zero_done: got count=%0d exp one pulse in cycle 1", dn.size());
    end
  endtask

  task automatic test_mid_reset();
    issue_cmd(10'h050, 11'd16, 10'd1);
    run(5, 0, -1);
    n_checks++;
    if (od.size() !== 3) begin
      n_fails++; $display("FAIL mreset_pre: got %0d words exp 3", od.size());
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({spad_read_req, out_valid, out_last, busy, done} !== 5'b0 || spad_r_addr !== 10'h000 || out_data !== 8'h00) begin
      n_fails++;
      $display("FAIL mreset_out: got ctrl=%b addr=%h data=%h exp 0/0/0",
               {spad_read_req, out_valid, out_last, busy, done}, spad_r_addr, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    issue_cmd(10'h100, 11'd2, 10'd1);
    run(8, 0, -1);
    n_checks++;
    if (rd_addr.size() !== 2 || od.size() !== 2) begin
      n_fails++; $display("FAIL mreset_count: got rd=%0d out=%0d exp 2/2", rd_addr.size(), od.size());
    end else begin
      n_checks++;
      if (rd_addr[0] !== 'h100 || rd_addr[1] !== 'h101 || od[0] !== 'hA5 || od[1] !== 'hA4 || ol[0] !== 0 || ol[1] !== 1) begin
        n_fails++;
        $display("FAIL mreset_words: got a=%h,%h d=%h,%h l=%0d%0d exp 100,101 a5,a4 01",
                 rd_addr[0], rd_addr[1], od[0], od[1], ol[0], ol[1]);
      end
    end
    n_checks++;
    if (dn.size() !== 1 || (dn.size() == 1 && dn[0] !== 5)) begin
      n_fails++; $display("FAIL mreset_done: got count=%0d exp one pulse in cycle 5", dn.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_d [3];
    exp_d = '{'hB5, 'hB4, 'hB7};
    issue_cmd(10'h200, 11'd2, 10'd1);
    run(4, 0, -1);
    issue_cmd(10'h210, 11'd3, 10'd1);
    run(10, 0, 2);
    n_checks++;
    if (dn.size() !== 2 || (dn.size() == 2 && (dn[0] !== 0 || dn[1] !== 6))) begin
      n_fails++; $display("FAIL b2b_done: got count=%0d exp pulses in cycles 0 and 6", dn.size());
    end
    n_checks++;
    if (rd_addr.size() !== 3 || od.size() !== 3) begin
      n_fails++; $display("FAIL b2b_count: got rd=%0d out=%0d exp 3/3", rd_addr.size(), od.size());
    end
    for (int k = 0; k < 3 && k < rd_addr.size() && k < od.size(); k++) begin
      n_checks++;
      if (rd_addr[k] !== 'h210 + k || od[k] !== exp_d[k] || rd_cyc[k] !== k + 1) begin
        n_fails++;
        $display("FAIL b2b[%0d]: got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                 k, rd_addr[k], od[k], rd_cyc[k], 'h210 + k, exp_d[k], k + 1);
      end
    end
  endtask

`ifdef SPAD_STREAM_STRIDE_EN
  task automatic test_stride();
    int exp_a [4];
    exp_a = '{0, 4, 8, 12};
    issue_cmd(10'h000, 11'd4, 10'd4);
    run(10, 0, -1);
    n_checks++;
    if (rd_addr.size() !== 4) begin
      n_fails++; $display("FAIL stride_count: got %0d exp 4", rd_addr.size());
    end
    for (int k = 0; k < 4 && k < rd_addr.size(); k++) begin
      n_checks++;
      if (rd_addr[k] !== exp_a[k]) begin
        n_fails++; $display("FAIL stride[%0d]: got addr=%h exp %h", k, rd_addr[k], exp_a[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_mid_reset();
    test_back_to_back();
`ifdef SPAD_STREAM_STRIDE_EN
    test_stride();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
